// File: rtl/modulo_controle_jogo.sv
// Game controller for the grid-attack game.
// The raw fire button is synchronized and debounced, and each debounced press
// becomes a one-cycle press event. That event drives the game FSM
// (SETUP -> ATTACK -> WIN/LOSE -> SETUP), which tracks the remaining shots,
// the confirmed hits and the cells already attacked in the current game.
module modulo_controle_jogo #(
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int MAX_SHOTS       = 12,
   parameter int TARGET_HITS     = 3
) (
   input  logic       clk,
   input  logic       clr,
   input  logic       btn_n,
   input  logic [5:0] sw_coord,
   input  logic       hit_in,
   output logic [1:0] hh1,
   output logic [5:0] hh2,
   output logic       fire_pulse,
   output logic [3:0] shots_left,
   output logic [2:0] hits
);

   localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [3:0]       SHOTS_INIT = 4'(MAX_SHOTS);
   localparam logic [2:0]       HITS_GOAL  = 3'(TARGET_HITS);

   // hh1 carries the state encoding directly, so the enum values are the status codes
   typedef enum logic [1:0] {
      ST_SETUP  = 2'b00,
      ST_ATTACK = 2'b01,
      ST_WIN    = 2'b10,
      ST_LOSE   = 2'b11
   } state_t;

   state_t           state;
   logic [1:0]       sync_ff;
   logic             btn_sync;
   logic             db_level;   // debounced button level, 1 = released
   logic [CNT_W-1:0] db_cnt;
   logic             press_evt;
   logic [34:0]      shot_map;

   logic [2:0]  row, col;
   logic        coord_ok;
   logic [5:0]  cell_idx;
   logic [34:0] cell_bit;
   logic        already_shot;
   logic [3:0]  shots_dec;
   logic [2:0]  hits_nxt;

   // Two-flop synchronizer; it resets to the released level so a held button is seen as a new press
   always_ff @(posedge clk or posedge clr) begin
      if (clr) sync_ff <= 2'b11;
      else     sync_ff <= {sync_ff[0], btn_n};
   end

   assign btn_sync = sync_ff[1];

   // Debouncer: accept a level change only after it has been stable for DEBOUNCE_CYCLES cycles;
   // only the released->pressed flip raises the one-cycle press event
   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         db_level  <= 1'b1;
         db_cnt    <= '0;
         press_evt <= 1'b0;
      end else begin
         press_evt <= 1'b0;
         if (btn_sync == db_level) begin
            db_cnt <= '0;
         end else if (db_cnt == CNT_LAST) begin
            db_level  <= btn_sync;
            db_cnt    <= '0;
            press_evt <= ~btn_sync;
         end else begin
            db_cnt <= db_cnt + 1'b1;
         end
      end
   end

   // Coordinate decode and the next counter values of a candidate shot
   assign row          = sw_coord[5:3];
   assign col          = sw_coord[2:0];
   assign coord_ok     = (row <= 3'd6) && (col <= 3'd4);
   assign cell_idx     = 6'({row, 2'b00}) + 6'(row) + 6'(col);
   assign cell_bit     = 35'd1 << cell_idx;   // out-of-grid indices shift out to zero
   assign already_shot = |(shot_map & cell_bit);
   assign shots_dec    = (shots_left != 4'd0) ? shots_left - 4'd1 : 4'd0;
   assign hits_nxt     = (hit_in && (hits < HITS_GOAL)) ? hits + 3'd1 : hits;

   // Game FSM with registered outputs. A press is refused while a strobe is still high,
   // so fire_pulse can never be asserted in two consecutive cycles.
   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         state      <= ST_SETUP;
         hh2        <= 6'd0;
         fire_pulse <= 1'b0;
         shots_left <= SHOTS_INIT;
         hits       <= 3'd0;
         shot_map   <= 35'd0;
      end else begin
         fire_pulse <= 1'b0;
         if (press_evt && !fire_pulse) begin
            case (state)
               ST_SETUP: begin
                  // setup press selects the preset through hh2, so it is not range-checked
                  hh2        <= sw_coord;
                  fire_pulse <= 1'b1;
                  state      <= ST_ATTACK;
               end
               ST_ATTACK: begin
                  if (coord_ok && !already_shot) begin
                     hh2        <= sw_coord;
                     fire_pulse <= 1'b1;
                     shot_map   <= shot_map | cell_bit;
                     shots_left <= shots_dec;
                     hits       <= hits_nxt;
                     // a win is tested first, so a winning last shot ends as WIN
                     if (hits_nxt == HITS_GOAL)  state <= ST_WIN;
                     else if (shots_dec == 4'd0) state <= ST_LOSE;
                  end
               end
               default: begin
                  state      <= ST_SETUP;
                  shots_left <= SHOTS_INIT;
                  hits       <= 3'd0;
                  shot_map   <= 35'd0;
               end
            endcase
         end
      end
   end

   assign hh1 = state;

endmodule

// File: tb/tb_modulo_controle_jogo.sv
// Scoreboard bench for modulo_controle_jogo with a small debounce window.
// The stimulus side models the game rules and queues the expected outputs of
// every fire_pulse. The monitor pops one entry on each pulse and compares it.
// Presses that must not fire are checked directly once the button is released.
module tb_modulo_controle_jogo;
   localparam int DB = 4;
   localparam int MS = 3;
   localparam int TH = 2;
   localparam int G_SETUP = 0, G_ATTACK = 1, G_WIN = 2, G_LOSE = 3;

   typedef struct {
      int hh1;
      int hh2;
      int shots;
      int hits;
   } exp_t;

   logic       clk = 1'b0;
   logic       clr = 1'b0;
   logic       btn_n = 1'b1;
   logic [5:0] sw_coord = 6'd0;
   logic       hit_in;
   logic [1:0] hh1;
   logic [5:0] hh2;
   logic       fire_pulse;
   logic [3:0] shots_left;
   logic [2:0] hits;

   int checks = 0;
   int failures = 0;
   exp_t exp_q[$];

   // reference model: game state expressed with plain integers and a set of attacked cells
   int m_state, m_hh2, m_shots, m_hits;
   bit m_shot[35];
   logic [34:0] board;   // occupied cells of the position matrix
   bit rand_board = 0;
   bit prev_fp = 0;

   modulo_controle_jogo #(.DEBOUNCE_CYCLES(DB), .MAX_SHOTS(MS), .TARGET_HITS(TH)) dut (
      .clk(clk), .clr(clr), .btn_n(btn_n), .sw_coord(sw_coord), .hit_in(hit_in),
      .hh1(hh1), .hh2(hh2), .fire_pulse(fire_pulse), .shots_left(shots_left), .hits(hits)
   );

   always #5 clk = ~clk;

   function automatic int cell_of(input logic [5:0] c);
      if (c[5:3] <= 3'd6 && c[2:0] <= 3'd4) return int'(c[5:3]) * 5 + int'(c[2:0]);
      return -1;
   endfunction

   function automatic logic [5:0] crd(input int r, input int c);
      logic [2:0] rr, cc;
      rr = 3'(r);
      cc = 3'(c);
      return {rr, cc};
   endfunction

   // position storage: the addressed cell is occupied
   always_comb begin
      hit_in = 1'b0;
      if (cell_of(sw_coord) >= 0) hit_in = board[cell_of(sw_coord)];
   end

   task automatic chk(input string name, input int got, input int expv);
      checks++;
      if (got != expv) begin
         failures++;
         $display("FAIL %s got=%0d expected=%0d at %0t", name, got, expv, $time);
      end
   endtask

   task automatic model_reset();
      m_state = G_SETUP; m_hh2 = 0; m_shots = MS; m_hits = 0;
      foreach (m_shot[i]) m_shot[i] = 0;
   endtask

   // applies the game rules to one press, returns whether a strobe is expected
   task automatic model_press(input logic [5:0] c, output bit pulse);
      int idx;
      pulse = 0;
      idx = cell_of(c);
      if (m_state == G_SETUP) begin
         pulse = 1; m_hh2 = int'(c); m_state = G_ATTACK;
      end else if (m_state == G_ATTACK) begin
         if (idx >= 0 && !m_shot[idx]) begin
            pulse = 1; m_hh2 = int'(c); m_shot[idx] = 1; m_shots--;
            if (board[idx]) m_hits++;
            if (m_hits >= TH) m_state = G_WIN;
            else if (m_shots == 0) m_state = G_LOSE;
         end
      end else begin
         m_state = G_SETUP; m_shots = MS; m_hits = 0;
         foreach (m_shot[i]) m_shot[i] = 0;
         if (rand_board) board = {$urandom, $urandom} & 35'h7_FFFF_FFFF;
      end
   endtask

   task automatic push_exp();
      exp_t e;
      e.hh1 = m_state; e.hh2 = m_hh2; e.shots = m_shots; e.hits = m_hits;
      exp_q.push_back(e);
   endtask

   task automatic check_state(input string tag);
      chk({tag, "_hh1"}, int'(hh1), m_state);
      chk({tag, "_hh2"}, int'(hh2), m_hh2);
      chk({tag, "_shots"}, int'(shots_left), m_shots);
      chk({tag, "_hits"}, int'(hits), m_hits);
   endtask

   task automatic hold(input logic lvl, input int n);
      for (int i = 0; i < n; i++) begin
         btn_n = lvl;
         @(negedge clk);
      end
   endtask

   // one press, optionally preceded by contact bounce
   task automatic press(input logic [5:0] c, input bit bounce);
      bit pulse;
      @(negedge clk);
      sw_coord = c;
      model_press(c, pulse);
      if (pulse) push_exp();
      if (bounce) begin
         hold(1'b0, 2); hold(1'b1, 2); hold(1'b0, 2); hold(1'b1, 2);
      end
      hold(1'b0, 10);
      hold(1'b1, 10);
      if (!pulse) check_state("nopulse");
   endtask

   // monitor: every strobe must match the oldest queued expectation
   always @(negedge clk) begin
      if (!clr && fire_pulse) begin
         chk("pulse_not_consecutive", int'(prev_fp), 0);
         if (exp_q.size() == 0) begin
            chk("unexpected_pulse", 1, 0);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("pulse_hh1", int'(hh1), e.hh1);
            chk("pulse_hh2", int'(hh2), e.hh2);
            chk("pulse_shots", int'(shots_left), e.shots);
            chk("pulse_hits", int'(hits), e.hits);
         end
      end
      prev_fp = clr ? 1'b0 : fire_pulse;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      board = 35'd0;
      board[13] = 1'b1;   // row 2 col 3
      board[20] = 1'b1;   // row 4 col 0
      model_reset();
      #1 clr = 1'b1;
      #1;
      chk("rst_fire", int'(fire_pulse), 0);
      check_state("rst");
      @(negedge clk);
      @(negedge clk);
      clr = 1'b0;
      @(negedge clk);

      // game 1: bounced first press, hit, repeat, out-of-grid, then out of shots
      press(crd(0, 0), 1);
      press(crd(2, 3), 0);
      press(crd(2, 3), 0);
      press(crd(7, 0), 0);
      press(crd(0, 5), 0);
      press(crd(0, 0), 0);
      press(crd(0, 1), 0);
      press(crd(3, 3), 0);
      // game 2: three misses lose, next press back to setup
      press(crd(1, 2), 0);
      press(crd(0, 0), 0);
      press(crd(0, 1), 0);
      press(crd(0, 2), 0);
      press(crd(5, 5), 0);
      // game 3: hit, miss, winning last shot
      press(crd(6, 4), 0);
      press(crd(2, 3), 0);
      press(crd(0, 0), 0);
      press(crd(4, 0), 0);
      press(crd(1, 1), 0);

      // reset in the middle of a debounce while the button stays held
      @(negedge clk);
      sw_coord = crd(3, 1);
      hold(1'b0, 2);
      #2 clr = 1'b1;
      #1;
      model_reset();
      chk("midrst_fire", int'(fire_pulse), 0);
      check_state("midrst");
      @(negedge clk);
      clr = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("post_rst_no_pulse", int'(fire_pulse), 0);
         chk("post_rst_hh1", int'(hh1), 0);
      end
      // the held button is a fresh press once it has been stable long enough
      m_state = G_ATTACK; m_hh2 = int'(crd(3, 1));
      push_exp();
      hold(1'b0, 10);
      hold(1'b1, 10);

      // random play against the model
      rand_board = 1;
      for (int i = 0; i < 60; i++) press(6'($urandom_range(0, 63)), $urandom_range(0, 3) == 0);

      hold(1'b1, 10);
      chk("queue_drained", exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/modulo_controle_jogo.md
MODULO_CONTROLE_JOGO -- requirements
Module: modulo_controle_jogo

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 500000: consecutive stable cycles (10 ms at 50 MHz) required to accept a button level change.
REQ-002 Parameter MAX_SHOTS, default 12: attack budget per game, range 1..15.
REQ-003 Parameter TARGET_HITS, default 3: hits that end the game as a win, range 1..7.
REQ-004 clk  in  1  system clock; sole clock; all state on rising edge.
REQ-005 clr  in  1  reset, asynchronous, active-high.
REQ-006 btn_n  in  1  raw fire button, active-low, asynchronous to clk, bouncing.
REQ-007 sw_coord  in  6  switches: [5:3] row, [2:0] column.
REQ-008 hit_in  in  1  position-matrix cell addressed by sw_coord is occupied (combinational from position storage).
REQ-009 hh1  out  2  game status: 00 SETUP, 01 ATTACK, 10 WIN, 11 LOSE.
REQ-010 hh2  out  6  last committed coordinate, same packing as sw_coord.
REQ-011 fire_pulse  out  1  one-cycle commit strobe, drives button_clk of the display/storage stage.
REQ-012 shots_left  out  4  remaining attacks.
REQ-013 hits  out  3  confirmed hits this game.

Function
REQ-014 btn_n SHALL pass a 2-flop synchronizer before any other use.
REQ-015 Debouncer: counter SHALL restart whenever synchronized level differs from debounced state; debounced state SHALL flip when counter reaches DEBOUNCE_CYCLES-1 with level still different.
REQ-016 press_evt SHALL assert exactly one cycle on debounced released->pressed transition; release SHALL generate no event.
REQ-017 Outputs SHALL be registered; response to press_evt in cycle N SHALL be visible in cycle N+1.
REQ-018 Coordinate valid iff row <= 6 and column <= 4; cell index = row*5 + column (0..34).
REQ-019 35-bit shot map SHALL record cells already attacked in the current game.
REQ-020 SETUP: press_evt -> hh2 <= sw_coord, fire_pulse = 1, go ATTACK; validity not checked (hh2[1:0] selects preset).
REQ-021 ATTACK, press_evt with invalid coordinate or already-shot cell: ignored; no pulse, no state or counter change.
REQ-022 ATTACK, accepted press: hh2 <= sw_coord, fire_pulse = 1, shot-map bit set, shots_left decremented, hits incremented if hit_in sampled high in cycle N.
REQ-023 After accepted press: hits reaching TARGET_HITS -> WIN; else shots_left reaching 0 -> LOSE; else stay ATTACK.
REQ-024 Final shot that is also the winning hit SHALL yield WIN (win priority).
REQ-025 WIN or LOSE: press_evt -> SETUP, shots_left <= MAX_SHOTS, hits <= 0, shot map cleared, hh2 unchanged, fire_pulse = 0.
REQ-026 shots_left SHALL never wrap below 0; hits SHALL never exceed TARGET_HITS.
REQ-027 fire_pulse SHALL never assert in two consecutive cycles.

Reset
REQ-028 clr high SHALL immediately force hh1 = 00, hh2 = 000000, fire_pulse = 0, shots_left = MAX_SHOTS, hits = 0, shot map = 0, debounced state = released, debounce counter = 0, synchronizer = released.
REQ-029 clr asserted mid-debounce SHALL discard the pending transition; no press_evt after release from reset until a full new debounce completes.
REQ-030 Button held through clr deassertion SHALL produce one press_evt after DEBOUNCE_CYCLES stable cycles.

Verification (DEBOUNCE_CYCLES = 4, MAX_SHOTS = 3, TARGET_HITS = 2)
REQ-031 Bounce 1-0-1-0 at 2-cycle spacing, then stable low 10 cycles -> exactly one fire_pulse; hh1 00 -> 01; hh2 = sw_coord.
REQ-032 ATTACK, sw_coord row 2 col 3, hit_in = 1, press -> fire_pulse, hits = 1, shots_left = 2; repeat same cell -> no pulse, counters unchanged.
REQ-033 sw_coord row 7 or col 5, press -> no pulse, hh1 stays 01, shots_left unchanged.
REQ-034 Three misses -> shots_left 0, hh1 = 11; next press -> hh1 = 00, shots_left = 3, hits = 0, no fire_pulse.
REQ-035 One hit, one miss, third shot hit -> hh1 = 10 (not 11), hits = 2, shots_left = 0.
REQ-036 clr pulse two cycles into debounce -> all outputs at reset values, no fire_pulse for next 4 cycles of stable low input.
